// File: rtl/qcmd_seq.sv
// qcmd_seq: timed command sequencer replaying a host-loaded program
// against a local timebase, with repetition, abort and late detection.
module qcmd_seq #(
    parameter int aw = 12,
    parameter int tw = 24,
    parameter int rw = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [aw-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          wstrobe,
    input  logic          start,
    input  logic          abort,
    input  logic [rw-1:0] nrep,
    input  logic          late_clr,
    output logic [63:0]   command,
    output logic [7:0]    cmda,
    output logic [30:0]   extra,
    output logic          cstrobe,
    output logic          busy,
    output logic          done,
    output logic          late
);
    localparam int dw = aw - 2;
    localparam int depth = 1 << dw;
    localparam logic [tw-1:0] cmax = '1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} st_t;

    logic [31:0]   m0 [0:depth-1];
    logic [31:0]   m1 [0:depth-1];
    logic [31:0]   m2 [0:depth-1];
    logic [31:0]   m3 [0:depth-1];
    logic [31:0]   d0, d1, d2, d3;
    logic [dw-1:0] widx;
    logic [dw-1:0] raddr;
    logic [dw-1:0] play;
    logic          rv1, rv2, valid, ldc;
    logic [tw-1:0] count;
    logic [rw-1:0] pass_left;
    st_t           st;

    logic [tw-1:0] etime;
    logic          eend;
    logic          fire;
    logic          unused_d0;

    assign widx      = waddr[aw-1:2];
    assign etime     = d0[8 +: tw];
    assign eend      = d3[31];
    assign fire      = (st == RUN) && valid && (count >= etime);
    assign unused_d0 = ^d0;

    // Program RAMs: registered read address (raddr) then registered data.
    always_ff @(posedge clk) begin
        if (wstrobe) begin
            unique case (waddr[1:0])
                2'd0: m0[widx] <= wdata;
                2'd1: m1[widx] <= wdata;
                2'd2: m2[widx] <= wdata;
                2'd3: m3[widx] <= wdata;
            endcase
        end
        if (rv1) begin
            d0 <= m0[raddr];
            d1 <= m1[raddr];
            d2 <= m2[raddr];
            d3 <= m3[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            ldc       <= 1'b0;
            rv1       <= 1'b0;
            rv2       <= 1'b0;
            valid     <= 1'b0;
            raddr     <= '0;
            play      <= '0;
            count     <= '0;
            pass_left <= '0;
            command   <= '0;
            cmda      <= '0;
            extra     <= '0;
            cstrobe   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            late      <= 1'b0;
        end else begin
            cstrobe <= 1'b0;
            done    <= 1'b0;
            rv1     <= 1'b0;
            rv2     <= rv1;
            if (late_clr)
                late <= 1'b0;
            if (rv2)
                valid <= 1'b1;
            if (abort) begin
                st    <= IDLE;
                busy  <= 1'b0;
                valid <= 1'b0;
                rv2   <= 1'b0;
            end else begin
                unique case (st)
                    IDLE: begin
                        if (start) begin
                            st        <= LOAD;
                            busy      <= 1'b1;
                            pass_left <= (nrep == '0) ? rw'(1) : nrep;
                            play      <= '0;
                            raddr     <= '0;
                            rv1       <= 1'b1;
                            ldc       <= 1'b0;
                            valid     <= 1'b0;
                        end
                    end
                    LOAD: begin
                        ldc   <= 1'b1;
                        count <= '0;
                        if (ldc)
                            st <= RUN;
                    end
                    RUN: begin
                        if (count != cmax)
                            count <= count + 1'b1;
                        if (fire) begin
                            command <= {d1, d2};
                            cmda    <= d0[7:0];
                            extra   <= d3[30:0];
                            cstrobe <= 1'b1;
                            valid   <= 1'b0;
                            if (count > etime)
                                late <= 1'b1;
                            if (eend && pass_left > rw'(1)) begin
                                pass_left <= pass_left - 1'b1;
                                play      <= '0;
                                raddr     <= '0;
                                rv1       <= 1'b1;
                                ldc       <= 1'b0;
                                st        <= LOAD;
                            end else if (eend) begin
                                st   <= IDLE;
                                busy <= 1'b0;
                                done <= 1'b1;
                            end else begin
                                play  <= play + 1'b1;
                                raddr <= play + 1'b1;
                                rv1   <= 1'b1;
                            end
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_qcmd_seq.sv
// tb_qcmd_seq: scoreboard bench for qcmd_seq with a small
// program memory (aw=4) and a short timebase (tw=6).
module tb_qcmd_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        wstrobe = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  nrep = '0;
    logic        late_clr = 1'b0;
    logic [63:0] command;
    logic [7:0]  cmda;
    logic [30:0] extra;
    logic        cstrobe, busy, done, late;

    qcmd_seq #(.aw(4), .tw(6), .rw(4)) dut (
        .clk(clk), .rst_n(rst_n), .waddr(waddr), .wdata(wdata),
        .wstrobe(wstrobe), .start(start), .abort(abort), .nrep(nrep),
        .late_clr(late_clr), .command(command), .cmda(cmda),
        .extra(extra), .cstrobe(cstrobe), .busy(busy), .done(done),
        .late(late)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [63:0] cmd;
        logic [7:0]  a;
        logic [30:0] x;
        logic        lt;
        logic        dn;
    } exp_t;
    exp_t q[$];

    logic [5:0]  p_t   [4];
    logic [63:0] p_cmd [4];
    logic [7:0]  p_a   [4];
    logic [30:0] p_x   [4];
    logic        p_end [4];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic wr(input int idx, input int w, input logic [31:0] d);
        waddr   = 4'((idx << 2) | w);
        wdata   = d;
        wstrobe = 1'b1;
        tick();
        wstrobe = 1'b0;
    endtask

    task automatic ent(input int idx, input logic [5:0] t,
                       input logic [7:0] a, input logic [63:0] cmd,
                       input logic e, input logic [30:0] x);
        p_t[idx] = t; p_a[idx] = a; p_cmd[idx] = cmd;
        p_end[idx] = e; p_x[idx] = x;
        wr(idx, 0, {18'd0, t, a});
        wr(idx, 1, cmd[63:32]);
        wr(idx, 2, cmd[31:0]);
        wr(idx, 3, {e, x});
    endtask

    task automatic push(input int c, input int idx, input logic lt,
                        input logic dn);
        exp_t e;
        e.c = c; e.cmd = p_cmd[idx]; e.a = p_a[idx]; e.x = p_x[idx];
        e.lt = lt; e.dn = dn;
        q.push_back(e);
    endtask

    task automatic go(input logic [3:0] n, output int s);
        nrep  = n;
        start = 1'b1;
        s     = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic clr_late();
        late_clr = 1'b1;
        tick();
        late_clr = 1'b0;
    endtask

    // Monitor: every strobe is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cstrobe) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: cmd %0h at cycle %0d",
                             command, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("strobe_cycle", 64'(cyc), 64'(e.c));
                    chk("command", command, e.cmd);
                    chk("cmda", 64'(cmda), 64'(e.a));
                    chk("extra", 64'(extra), 64'(e.x));
                    chk("late_at_strobe", 64'(late), 64'(e.lt));
                    chk("done_at_strobe", 64'(done), 64'(e.dn));
                end
            end else if (done) begin
                n_chk++;
                n_fail++;
                $display("FAIL done_without_strobe: got 1 want 0 at %0d",
                         cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        #1;
        chk("rst_command", command, 64'd0);
        chk("rst_cstrobe", 64'(cstrobe), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_late", 64'(late), 64'd0);
        chk("rst_count", 64'(dut.count), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        ent(0, 6'd5,  8'hA0, 64'h1111_2222_3333_4444, 1'b0, 31'h0101);
        ent(1, 6'd10, 8'hA1, 64'h5555_6666_7777_8888, 1'b0, 31'h0202);
        ent(2, 6'd20, 8'hA2, 64'h9999_AAAA_BBBB_CCCC, 1'b1, 31'h0303);
        ent(3, 6'd40, 8'hA3, 64'hDDDD_EEEE_FFFF_0000, 1'b0, 31'h0404);

        // single pass
        tick();
        go(4'd1, s);
        push(s + 9, 0, 1'b0, 1'b0);
        push(s + 14, 1, 1'b0, 1'b0);
        push(s + 24, 2, 1'b0, 1'b1);
        wait_until(s + 1);
        chk("busy_after_start", 64'(busy), 64'd1);
        wait_until(s + 24);
        chk("busy_end_t1", 64'(busy), 64'd0);
        chk("late_t1", 64'(late), 64'd0);
        wait_until(s + 30);

        // three passes, 23 cycles apart
        go(4'd3, s);
        for (int p = 0; p < 3; p++) begin
            push(s + 9 + 23 * p, 0, 1'b0, 1'b0);
            push(s + 14 + 23 * p, 1, 1'b0, 1'b0);
            push(s + 24 + 23 * p, 2, 1'b0, p == 2);
        end
        wait_until(s + 71);
        chk("busy_end_t2", 64'(busy), 64'd0);
        chk("queue_t2", 64'(q.size()), 64'd0);

        // close spacing: second fire waits for fetch, flagged late
        ent(1, 6'd6, 8'hB1, 64'h0123_4567_89AB_CDEF, 1'b1, 31'h0505);
        tick();
        go(4'd1, s);
        push(s + 9, 0, 1'b0, 1'b0);
        push(s + 12, 1, 1'b1, 1'b1);
        wait_until(s + 14);
        clr_late();
        chk("late_cleared", 64'(late), 64'd0);
        go(4'd0, s);
        push(s + 9, 0, 1'b0, 1'b0);
        push(s + 12, 1, 1'b1, 1'b1);
        wait_until(s + 11);
        clr_late();
        chk("late_set_beats_clr", 64'(late), 64'd1);
        tick();
        clr_late();
        chk("late_cleared2", 64'(late), 64'd0);

        // abort on entry 1's fire cycle, with a start that must be ignored
        ent(1, 6'd10, 8'hC1, 64'hCAFE_0000_0000_BEEF, 1'b1, 31'h0606);
        tick();
        go(4'd1, s);
        push(s + 9, 0, 1'b0, 1'b0);
        wait_until(s + 13);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("busy_after_abort", 64'(busy), 64'd0);
        wait_until(s + 40);
        chk("busy_after_ignored_start", 64'(busy), 64'd0);
        chk("queue_t4", 64'(q.size()), 64'd0);

        // no END: wraps over all 4 entries, count saturates at 63
        ent(0, 6'd10, 8'hD0, 64'h0000_0000_0000_00D0, 1'b0, 31'h0707);
        ent(1, 6'd20, 8'hD1, 64'h0000_0000_0000_00D1, 1'b0, 31'h0808);
        ent(2, 6'd30, 8'hD2, 64'h0000_0000_0000_00D2, 1'b0, 31'h0909);
        ent(3, 6'd40, 8'hD3, 64'h0000_0000_0000_00D3, 1'b0, 31'h0A0A);
        tick();
        go(4'd1, s);
        for (int i = 0; i < 4; i++)
            push(s + 14 + 10 * i, i, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++)
            push(s + 47 + 3 * k, k % 4, 1'b1, 1'b0);
        wait_until(s + 70);
        chk("count_saturated", 64'(dut.count), 64'd63);
        wait_until(s + 75);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("busy_after_abort_t5", 64'(busy), 64'd0);
        wait_until(s + 90);
        chk("queue_t5", 64'(q.size()), 64'd0);

        // async reset mid-run, then replay of the retained program
        ent(3, 6'd40, 8'hD3, 64'h0000_0000_0000_00D3, 1'b1, 31'h0A0A);
        tick();
        go(4'd1, s);
        push(s + 14, 0, 1'b1, 1'b0);
        wait_until(s + 16);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_command", command, 64'd0);
        chk("arst_cmda", 64'(cmda), 64'd0);
        chk("arst_extra", 64'(extra), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_late", 64'(late), 64'd0);
        chk("arst_cstrobe", 64'(cstrobe), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("queue_before_replay", 64'(q.size()), 64'd0);
        go(4'd1, s);
        for (int i = 0; i < 4; i++)
            push(s + 14 + 10 * i, i, 1'b0, i == 3);
        wait_until(s + 50);
        chk("busy_end_t6", 64'(busy), 64'd0);
        chk("queue_final", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
